// File: rtl/survivor_mmu.sv
`default_nettype none
// ============================================================================
// Module   : survivor_mmu
// Purpose  : Paged survivor-memory manager for a Viterbi decoder. The ACS
//            array writes one survivor word per cycle into a page/segment
//            ring. Traceback reads words back with one cycle of latency and
//            releases the oldest completed page when it is done with it.
// Ports    : CLOCK, Reset             - clock, synchronous active-high reset
//            Active, Init             - block enable, synchronous restart
//            wr_valid, Survivors      - survivor word offered by ACS
//            wr_ready                 - write accepted this cycle
//            ACSPage, ACSSegment      - address of the next write
//            rd_req, AddressTB        - traceback read request/address
//            rd_ready                 - read accepted this cycle
//            DataTB, rd_valid, rd_err - read response
//            tb_release               - free the oldest filled page
//            fill_count, full, empty  - completed-page occupancy
//            overflow                 - sticky dropped-write flag
// Revision : 1.0 - initial release
// ============================================================================
module survivor_mmu #(
  parameter int N_ACS       = 8,
  parameter int WD_SEG      = 2,
  parameter int WD_PAGE     = 2,
  parameter int SINGLE_PORT = 1,
  localparam int AW         = WD_PAGE + WD_SEG,
  localparam int SEGS       = 2 ** WD_SEG,
  localparam int PAGES      = 2 ** WD_PAGE
) (
  input  logic               CLOCK,
  input  logic               Reset,
  input  logic               Active,
  input  logic               Init,
  input  logic               wr_valid,
  input  logic [N_ACS-1:0]   Survivors,
  output logic               wr_ready,
  output logic [WD_PAGE-1:0] ACSPage,
  output logic [WD_SEG-1:0]  ACSSegment,
  input  logic               rd_req,
  input  logic [AW-1:0]      AddressTB,
  output logic               rd_ready,
  output logic [N_ACS-1:0]   DataTB,
  output logic               rd_valid,
  output logic               rd_err,
  input  logic               tb_release,
  output logic [WD_PAGE:0]   fill_count,
  output logic               full,
  output logic               empty,
  output logic               overflow
);

  // Survivor RAM; contents are deliberately never reset.
  logic [N_ACS-1:0]   mem_q [PAGES*SEGS];

  logic [WD_SEG-1:0]  seg_q,   seg_d;
  logic [WD_PAGE-1:0] page_q,  page_d;
  logic [WD_PAGE-1:0] base_q,  base_d;
  logic [WD_PAGE:0]   fill_q,  fill_d;
  logic               ovf_q,   ovf_d;
  logic               rvld_q,  rvld_d;
  logic               rerr_q,  rerr_d;
  logic [N_ACS-1:0]   data_q;

  logic               w_full;
  logic               w_wr_acc;
  logic               w_rd_acc;
  logic               w_page_done;
  logic               w_release;
  logic [WD_PAGE-1:0] w_rd_dist;
  logic               w_rd_err;
  logic               w_rd_ready;

  // fill_count never exceeds PAGES, so its MSB alone marks the full state.
  assign w_full   = fill_q[WD_PAGE];
  assign wr_ready = Active & ~Init & ~Reset & ~w_full;
  assign w_wr_acc = wr_valid & wr_ready;

  generate
    if (SINGLE_PORT != 0) begin : g_single_port
      // One RAM access per cycle: a write steals the port from a read.
      assign w_rd_ready = Active & ~Init & ~Reset & ~w_wr_acc;
    end else begin : g_dual_port
      assign w_rd_ready = Active & ~Init & ~Reset;
    end
  endgenerate

  assign rd_ready = w_rd_ready;
  assign w_rd_acc = rd_req & w_rd_ready;

  // Distance of the requested page from the oldest filled page, modulo the
  // ring size; anything at or beyond fill_count is not a completed page.
  assign w_rd_dist = AddressTB[AW-1:WD_SEG] - base_q;
  assign w_rd_err  = ({1'b0, w_rd_dist} >= fill_q);

  assign w_page_done = w_wr_acc & (seg_q == {WD_SEG{1'b1}});
  assign w_release   = tb_release & (fill_q != '0);

  always_comb begin
    seg_d  = seg_q;
    page_d = page_q;
    base_d = base_q;
    fill_d = fill_q;
    ovf_d  = ovf_q;
    rvld_d = w_rd_acc;
    rerr_d = w_rd_acc & w_rd_err;

    if (w_wr_acc) begin
      seg_d = seg_q + 1'b1;
      if (w_page_done) begin
        page_d = page_q + 1'b1;
      end
    end

    if (w_release) begin
      base_d = base_q + 1'b1;
    end

    // Completion and release in the same cycle cancel out.
    if (w_page_done && !w_release) begin
      fill_d = fill_q + 1'b1;
    end else if (!w_page_done && w_release) begin
      fill_d = fill_q - 1'b1;
    end

    if (wr_valid && !wr_ready && Active) begin
      ovf_d = 1'b1;
    end

    if (Init) begin
      seg_d  = '0;
      page_d = '0;
      base_d = '0;
      fill_d = '0;
      ovf_d  = 1'b0;
      rvld_d = 1'b0;
      rerr_d = 1'b0;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      seg_q  <= '0;
      page_q <= '0;
      base_q <= '0;
      fill_q <= '0;
      ovf_q  <= 1'b0;
      rvld_q <= 1'b0;
      rerr_q <= 1'b0;
    end else begin
      seg_q  <= seg_d;
      page_q <= page_d;
      base_q <= base_d;
      fill_q <= fill_d;
      ovf_q  <= ovf_d;
      rvld_q <= rvld_d;
      rerr_q <= rerr_d;
    end
  end

  // Read register: holds the last word when no read is accepted. A same-cycle
  // read of the address being written sees the old word (dual-port case).
  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      data_q <= '0;
    end else if (w_rd_acc) begin
      data_q <= mem_q[AddressTB];
    end
  end

  always_ff @(posedge CLOCK) begin
    if (w_wr_acc) begin
      mem_q[{page_q, seg_q}] <= Survivors;
    end
  end

  assign ACSPage    = page_q;
  assign ACSSegment = seg_q;
  assign DataTB     = data_q;
  assign rd_valid   = rvld_q;
  assign rd_err     = rerr_q;
  assign fill_count = fill_q;
  assign full       = w_full;
  assign empty      = (fill_q == '0);
  assign overflow   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_survivor_mmu.sv
`default_nettype none
// ============================================================================
// Module   : tb_survivor_mmu
// Purpose  : Directed, self-checking bench for survivor_mmu (default params).
//            Reads push their expected {rd_err, DataTB} into a queue; a
//            monitor pops and compares whenever rd_valid is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_survivor_mmu;

  logic       clk;
  logic       Reset, Active, Init;
  logic       wr_valid;
  logic [7:0] Survivors;
  logic       wr_ready;
  logic [1:0] ACSPage;
  logic [1:0] ACSSegment;
  logic       rd_req;
  logic [3:0] AddressTB;
  logic       rd_ready;
  logic [7:0] DataTB;
  logic       rd_valid, rd_err;
  logic       tb_release;
  logic [2:0] fill_count;
  logic       full, empty, overflow;

  int n_cmp  = 0;
  int n_bad  = 0;
  logic [8:0] exp_q [$];

  survivor_mmu #(
    .N_ACS(8), .WD_SEG(2), .WD_PAGE(2), .SINGLE_PORT(1)
  ) dut (
    .CLOCK(clk), .Reset(Reset), .Active(Active), .Init(Init),
    .wr_valid(wr_valid), .Survivors(Survivors), .wr_ready(wr_ready),
    .ACSPage(ACSPage), .ACSSegment(ACSSegment),
    .rd_req(rd_req), .AddressTB(AddressTB), .rd_ready(rd_ready),
    .DataTB(DataTB), .rd_valid(rd_valid), .rd_err(rd_err),
    .tb_release(tb_release), .fill_count(fill_count),
    .full(full), .empty(empty), .overflow(overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every rd_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rd_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rd_unexpected: got err=%0b data=0x%0h expected no read", rd_err, DataTB);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({rd_err, DataTB} !== e) begin
          n_bad++;
          $display("FAIL rd_data: got err=%0b data=0x%0h expected err=%0b data=0x%0h",
                   rd_err, DataTB, e[8], e[7:0]);
        end
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic wr(input logic [7:0] d);
    wr_valid  = 1'b1;
    Survivors = d;
    @(posedge clk); #1;
    wr_valid  = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] d, input logic e);
    rd_req    = 1'b1;
    AddressTB = a;
    #1;
    chk("rd_ready", rd_ready, 1);
    exp_q.push_back({e, d});
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  task automatic pulse_init();
    Init = 1'b1;
    @(posedge clk); #1;
    Init = 1'b0;
  endtask

  task automatic pulse_release();
    tb_release = 1'b1;
    @(posedge clk); #1;
    tb_release = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Active = 1'b1; Init = 1'b0;
    wr_valid = 1'b0; Survivors = '0;
    rd_req = 1'b0; AddressTB = '0; tb_release = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_ready", rd_ready, 0);
    Reset = 1'b0;
    chk("rst_seg", ACSSegment, 0);
    chk("rst_page", ACSPage, 0);
    chk("rst_fill", fill_count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_rvalid", rd_valid, 0);
    chk("rst_data", DataTB, 0);

    // First page and a read from it
    for (int i = 0; i < 4; i++) wr(8'(i));
    chk("p0_fill", fill_count, 1);
    chk("p0_page", ACSPage, 1);
    chk("p0_seg", ACSSegment, 0);
    chk("p0_empty", empty, 0);
    rd(4'd2, 8'h02, 1'b0);

    // Read of the partially written page flags rd_err but returns data
    wr(8'h10);
    rd(4'd4, 8'h10, 1'b1);
    wr(8'h11); wr(8'h12); wr(8'h13);
    chk("p1_fill", fill_count, 2);
    chk("p1_page", ACSPage, 2);

    // Write and read collide: write wins, read accepted next cycle
    wr_valid = 1'b1; Survivors = 8'h20; rd_req = 1'b1; AddressTB = 4'd8;
    #1;
    chk("coll_rd_ready", rd_ready, 0);
    chk("coll_wr_ready", wr_ready, 1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    #1;
    chk("coll_rd_ready2", rd_ready, 1);
    exp_q.push_back({1'b1, 8'h20});
    @(posedge clk); #1;
    rd_req = 1'b0;
    chk("coll_seg", ACSSegment, 1);

    // Page completion with simultaneous release
    wr(8'h21); wr(8'h22);
    chk("cr_fill_pre", fill_count, 2);
    wr_valid = 1'b1; Survivors = 8'h23; tb_release = 1'b1;
    @(posedge clk); #1;
    wr_valid = 1'b0; tb_release = 1'b0;
    chk("cr_fill", fill_count, 2);
    chk("cr_page", ACSPage, 3);
    chk("cr_seg", ACSSegment, 0);
    rd(4'd0, 8'h00, 1'b1);   // page 0 released: base is now 1
    rd(4'd4, 8'h10, 1'b0);
    rd(4'd8, 8'h20, 1'b0);

    // Init dominates every request in the same cycle
    Init = 1'b1; wr_valid = 1'b1; Survivors = 8'hEE; rd_req = 1'b1; tb_release = 1'b1;
    #1;
    chk("init_wr_ready", wr_ready, 0);
    chk("init_rd_ready", rd_ready, 0);
    @(posedge clk); #1;
    Init = 1'b0; wr_valid = 1'b0; rd_req = 1'b0; tb_release = 1'b0;
    chk("init_fill", fill_count, 0);
    chk("init_page", ACSPage, 0);
    chk("init_seg", ACSSegment, 0);
    chk("init_ovf", overflow, 0);
    chk("init_empty", empty, 1);

    // Release while empty is ignored
    pulse_release();
    chk("erel_fill", fill_count, 0);
    chk("erel_empty", empty, 1);

    // Fill all four pages
    for (int i = 0; i < 16; i++) wr(8'(8'h80 + i));
    chk("full_full", full, 1);
    chk("full_fill", fill_count, 4);
    chk("full_wr_ready", wr_ready, 0);
    chk("full_page", ACSPage, 0);
    rd(4'd1, 8'h81, 1'b0);   // base still 0 after the ignored release
    wr_valid = 1'b1; Survivors = 8'hFF;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_page", ACSPage, 0);
    chk("ovf_seg", ACSSegment, 0);
    chk("ovf_fill", fill_count, 4);
    rd(4'd0, 8'h80, 1'b0);   // dropped word did not overwrite page 0
    pulse_release();
    chk("rel_fill", fill_count, 3);
    chk("rel_full", full, 0);
    chk("rel_wr_ready", wr_ready, 1);
    chk("rel_ovf_sticky", overflow, 1);

    // Inactive block accepts nothing and raises no overflow
    pulse_init();
    Active = 1'b0; wr_valid = 1'b1; Survivors = 8'h55;
    @(posedge clk); #1;
    wr_valid = 1'b0; Active = 1'b1;
    chk("inact_seg", ACSSegment, 0);
    chk("inact_ovf", overflow, 0);

    // Reset mid-page
    wr(8'hA0); wr(8'hA1);
    chk("mid_seg", ACSSegment, 2);
    Reset = 1'b1;
    @(posedge clk); #1;
    Reset = 1'b0;
    chk("mrst_seg", ACSSegment, 0);
    chk("mrst_page", ACSPage, 0);
    chk("mrst_fill", fill_count, 0);
    chk("mrst_empty", empty, 1);
    chk("mrst_data", DataTB, 0);
    rd(4'd0, 8'hA0, 1'b1);

    // Init mid-page
    wr(8'hB0); wr(8'hB1);
    chk("mid2_seg", ACSSegment, 2);
    pulse_init();
    chk("minit_seg", ACSSegment, 0);
    chk("minit_fill", fill_count, 0);
    chk("minit_empty", empty, 1);
    rd(4'd0, 8'hB0, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("pending_reads", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/survivor_mmu.md
SURVIVOR_MMU -- requirements
Module: survivor_mmu

Interface
REQ-001 Parameter N_ACS, default 8: survivor bits per RAM word, one bit per ACS unit.
REQ-002 Parameter WD_SEG, default 2: segment index width; SEGS = 2**WD_SEG words per page.
REQ-003 Parameter WD_PAGE, default 2: page index width; PAGES = 2**WD_PAGE pages.
REQ-004 Parameter SINGLE_PORT, default 1: 1 = one RAM access per cycle, write has priority; 0 = independent read and write ports.
REQ-005 Derived AW = WD_PAGE+WD_SEG; RAM word address = {page, segment}.
REQ-006 CLOCK  in  1  sole clock; all logic on rising edge.
REQ-007 Reset  in  1  synchronous, active-high.
REQ-008 Active  in  1  block enable; when low, no write or read is accepted.
REQ-009 Init  in  1  synchronous restart of pointers and flags; RAM contents kept.
REQ-010 wr_valid  in  1  survivor word offered.
REQ-011 Survivors  in  N_ACS  survivor word.
REQ-012 wr_ready  out  1  write accepted this cycle when wr_valid=1.
REQ-013 ACSPage  out  WD_PAGE  page of next write.
REQ-014 ACSSegment  out  WD_SEG  segment of next write.
REQ-015 rd_req  in  1  traceback read request.
REQ-016 AddressTB  in  AW  traceback read address {page, segment}.
REQ-017 rd_ready  out  1  read accepted this cycle when rd_req=1.
REQ-018 DataTB  out  N_ACS  read data.
REQ-019 rd_valid  out  1  DataTB and rd_err valid.
REQ-020 rd_err  out  1  accepted read targeted a page not in the filled set.
REQ-021 tb_release  in  1  traceback done with oldest filled page; frees it.
REQ-022 fill_count  out  WD_PAGE+1  number of completed, unreleased pages.
REQ-023 full / empty  out  1 each  fill_count==PAGES / fill_count==0.
REQ-024 overflow  out  1  sticky: write offered while wr_ready=0 and Active=1.

Function
REQ-025 Write pointer {ACSPage, ACSSegment} increments by 1 per accepted write; segment wraps SEGS-1 -> 0 and page advances mod PAGES.
REQ-026 A write accepted with ACSSegment==SEGS-1 completes a page: fill_count +1 on the next edge.
REQ-027 base_page register: oldest filled page. tb_release with fill_count>0 advances base_page mod PAGES and decrements fill_count; with fill_count==0 it is ignored.
REQ-028 Page completion and release in the same cycle: fill_count unchanged, base_page advances.
REQ-029 wr_ready = Active & ~Init & ~Reset & ~full (combinational); when full, write page == base_page and is never overwritten.
REQ-030 wr_valid & ~wr_ready & Active sets overflow; the word is dropped and the pointer holds.
REQ-031 SINGLE_PORT=1: rd_ready = Active & ~Init & ~(wr_valid & wr_ready); SINGLE_PORT=0: rd_ready = Active & ~Init.
REQ-032 Read latency: request accepted in cycle n -> rd_valid=1 and DataTB in cycle n+1; rd_valid is 0 otherwise and DataTB holds its last value.
REQ-033 Read of an address written in an earlier cycle returns the new data; with SINGLE_PORT=0, a same-cycle read of the written address returns the old data.
REQ-034 rd_err=1 with rd_valid when ((page - base_page) mod PAGES) >= fill_count at acceptance, including the partially written page; data is still returned.
REQ-035 Init=1: pointers, base_page and fill_count go to 0, overflow, rd_valid and rd_err are cleared, no access is accepted; Init dominates wr_valid, rd_req and tb_release.

Reset
REQ-036 Reset=1 at a rising edge: ACSPage=0, ACSSegment=0, base_page=0, fill_count=0, full=0, empty=1, overflow=0, rd_valid=0, rd_err=0, DataTB=0; wr_ready=0 and rd_ready=0 while Reset=1.
REQ-037 RAM contents are not reset. Reset mid-read drops the pending rd_valid. Reset mid-page discards the partial page.

Verification (defaults: N_ACS=8, 4 segs, 4 pages)
REQ-038 Write 0x00..0x03 -> fill_count=1 one cycle after the 4th write, ACSPage=1, ACSSegment=0; read addr 2 -> DataTB=0x02 next cycle, rd_err=0.
REQ-039 Write 16 words -> full=1 and wr_ready=0; a 17th wr_valid -> overflow=1 and pointer stays 0/0; tb_release -> fill_count=3 and wr_ready=1.
REQ-040 SINGLE_PORT=1, wr_valid and rd_req in the same cycle -> rd_ready=0 and the write lands; the read is accepted the next cycle and returns the correct data.
REQ-041 Read page 1 while only page 0 is filled -> rd_valid=1 with rd_err=1; release with empty=1 -> no change.
REQ-042 Page-completing write plus tb_release in the same cycle with fill_count=2 -> fill_count stays 2 and base_page +1.
REQ-043 Reset and Init mid-page (ACSSegment=2) -> all counters 0, empty=1; the following read of addr 0 returns the pre-reset RAM data with rd_err=1.
